// File: rtl/sc_reg_universal_if.sv
// Bus bundle for sc_reg_universal: controls, parallel data and status flags.
// The master drives controls and data; the slave (the register) drives contents and flags.
`default_nettype none

interface sc_reg_universal_if #(
  parameter int RegUNIVERSAL_DATAWIDTH = 8
);
  logic                              SC_RegUNIVERSAL_clear_InLow;
  logic                              SC_RegUNIVERSAL_load_InLow;
  logic [2:0]                        SC_RegUNIVERSAL_mode_InBUS;
  logic                              SC_RegUNIVERSAL_serial_In;
  logic [RegUNIVERSAL_DATAWIDTH-1:0] SC_RegUNIVERSAL_data_InBUS;
  logic [RegUNIVERSAL_DATAWIDTH-1:0] SC_RegUNIVERSAL_data_OutBUS;
  logic                              SC_RegUNIVERSAL_carry_OutLow;
  logic                              SC_RegUNIVERSAL_zero_OutLow;
  logic                              SC_RegUNIVERSAL_negative_OutLow;

  modport master (
    output SC_RegUNIVERSAL_clear_InLow,
    output SC_RegUNIVERSAL_load_InLow,
    output SC_RegUNIVERSAL_mode_InBUS,
    output SC_RegUNIVERSAL_serial_In,
    output SC_RegUNIVERSAL_data_InBUS,
    input  SC_RegUNIVERSAL_data_OutBUS,
    input  SC_RegUNIVERSAL_carry_OutLow,
    input  SC_RegUNIVERSAL_zero_OutLow,
    input  SC_RegUNIVERSAL_negative_OutLow
  );

  modport slave (
    input  SC_RegUNIVERSAL_clear_InLow,
    input  SC_RegUNIVERSAL_load_InLow,
    input  SC_RegUNIVERSAL_mode_InBUS,
    input  SC_RegUNIVERSAL_serial_In,
    input  SC_RegUNIVERSAL_data_InBUS,
    output SC_RegUNIVERSAL_data_OutBUS,
    output SC_RegUNIVERSAL_carry_OutLow,
    output SC_RegUNIVERSAL_zero_OutLow,
    output SC_RegUNIVERSAL_negative_OutLow
  );
endinterface

`default_nettype wire

// File: rtl/sc_reg_universal.sv
// sc_reg_universal: width-generic register with clear/load, shift, rotate, inc/dec modes
// and a registered carry flag plus combinational zero/negative flags (all active low).
`default_nettype none

module sc_reg_universal #(
  parameter int RegUNIVERSAL_DATAWIDTH = 8
) (
  input  logic                   SC_RegUNIVERSAL_CLOCK_50,
  input  logic                   SC_RegUNIVERSAL_RESET_InLow,
  sc_reg_universal_if.slave      bus
);
  localparam int W = RegUNIVERSAL_DATAWIDTH;

  localparam logic [2:0] c_mode_shl  = 3'b001;
  localparam logic [2:0] c_mode_shr  = 3'b010;
  localparam logic [2:0] c_mode_rotl = 3'b011;
  localparam logic [2:0] c_mode_rotr = 3'b100;
  localparam logic [2:0] c_mode_inc  = 3'b101;
  localparam logic [2:0] c_mode_dec  = 3'b110;

  logic [W-1:0] data_d, data_q;
  logic         carry_d, carry_q;  // active-high internally
  logic [W:0]   arith_sum;
  logic [W:0]   arith_diff;

  // The extra top bit of the widened result is the carry-out / borrow.
  assign arith_sum  = {1'b0, data_q} + {{W{1'b0}}, 1'b1};
  assign arith_diff = {1'b0, data_q} - {{W{1'b0}}, 1'b1};

  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    if (!bus.SC_RegUNIVERSAL_clear_InLow) begin
      data_d  = '0;
      carry_d = 1'b0;
    end else if (!bus.SC_RegUNIVERSAL_load_InLow) begin
      data_d  = bus.SC_RegUNIVERSAL_data_InBUS;
      carry_d = 1'b0;
    end else begin
      case (bus.SC_RegUNIVERSAL_mode_InBUS)
        c_mode_shl: begin
          data_d  = {data_q[W-2:0], bus.SC_RegUNIVERSAL_serial_In};
          carry_d = data_q[W-1];
        end
        c_mode_shr: begin
          data_d  = {bus.SC_RegUNIVERSAL_serial_In, data_q[W-1:1]};
          carry_d = data_q[0];
        end
        c_mode_rotl: begin
          data_d  = {data_q[W-2:0], data_q[W-1]};
          carry_d = data_q[W-1];
        end
        c_mode_rotr: begin
          data_d  = {data_q[0], data_q[W-1:1]};
          carry_d = data_q[0];
        end
        c_mode_inc: begin
          data_d  = arith_sum[W-1:0];
          carry_d = arith_sum[W];
        end
        c_mode_dec: begin
          data_d  = arith_diff[W-1:0];
          carry_d = arith_diff[W];
        end
        default: begin
          data_d  = data_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  always_ff @(posedge SC_RegUNIVERSAL_CLOCK_50 or negedge SC_RegUNIVERSAL_RESET_InLow) begin
    if (!SC_RegUNIVERSAL_RESET_InLow) begin
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign bus.SC_RegUNIVERSAL_data_OutBUS     = data_q;
  assign bus.SC_RegUNIVERSAL_carry_OutLow    = ~carry_q;
  assign bus.SC_RegUNIVERSAL_zero_OutLow     = |data_q;
  assign bus.SC_RegUNIVERSAL_negative_OutLow = ~data_q[W-1];

endmodule

`default_nettype wire

// File: tb/tb_sc_reg_universal.sv
// Scoreboard bench for sc_reg_universal (W=8): directed vectors plus a model-checked random run.
`default_nettype none

module tb_sc_reg_universal;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  event sample_ev;

  typedef struct {
    logic [7:0] data;
    logic       cn;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  sc_reg_universal_if #(.RegUNIVERSAL_DATAWIDTH(8)) bus ();

  sc_reg_universal #(.RegUNIVERSAL_DATAWIDTH(8)) dut (
    .SC_RegUNIVERSAL_CLOCK_50    (clk),
    .SC_RegUNIVERSAL_RESET_InLow (rst_n),
    .bus                         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [7:0] d, input logic cn, input string nm);
    exp_t e;
    e.data = d;
    e.cn   = cn;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Drive one operation at the falling edge; its result is expected after the next rising edge.
  task automatic op(input logic rn, input logic cl, input logic ld, input logic [2:0] md,
                    input logic sr, input logic [7:0] di,
                    input logic [7:0] ed, input logic ecn, input string nm);
    @(negedge clk);
    rst_n                          = rn;
    bus.SC_RegUNIVERSAL_clear_InLow = cl;
    bus.SC_RegUNIVERSAL_load_InLow  = ld;
    bus.SC_RegUNIVERSAL_mode_InBUS  = md;
    bus.SC_RegUNIVERSAL_serial_In   = sr;
    bus.SC_RegUNIVERSAL_data_InBUS  = di;
    push(ed, ecn, nm);
  endtask

  // Monitor: outputs are valid every cycle, so drain the scoreboard after each edge or async event.
  initial begin
    exp_t e;
    logic exp_zn, exp_nn;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        exp_zn = (e.data != 8'h00);
        exp_nn = ~e.data[7];
        n_vec++;
        if (bus.SC_RegUNIVERSAL_data_OutBUS     !== e.data ||
            bus.SC_RegUNIVERSAL_carry_OutLow    !== e.cn   ||
            bus.SC_RegUNIVERSAL_zero_OutLow     !== exp_zn ||
            bus.SC_RegUNIVERSAL_negative_OutLow !== exp_nn) begin
          n_bad++;
          $display("FAIL %s: got data=%h cn=%b zn=%b nn=%b, expected data=%h cn=%b zn=%b nn=%b",
                   e.name, bus.SC_RegUNIVERSAL_data_OutBUS, bus.SC_RegUNIVERSAL_carry_OutLow,
                   bus.SC_RegUNIVERSAL_zero_OutLow, bus.SC_RegUNIVERSAL_negative_OutLow,
                   e.data, e.cn, exp_zn, exp_nn);
        end
      end
    end
  end

  initial begin
    logic [7:0] m_r, nx_r, din;
    logic       m_c, nx_c, rn, cl, ld, sr;
    logic [2:0] md;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.SC_RegUNIVERSAL_clear_InLow = 1'b1;
    bus.SC_RegUNIVERSAL_load_InLow  = 1'b1;
    bus.SC_RegUNIVERSAL_mode_InBUS  = 3'b000;
    bus.SC_RegUNIVERSAL_serial_In   = 1'b0;
    bus.SC_RegUNIVERSAL_data_InBUS  = 8'h00;

    @(negedge clk);
    push(8'h00, 1'b1, "reset_state");
    -> sample_ev;

    op(1, 1, 1, 3'b000, 0, 8'h00, 8'h00, 1'b1, "post_reset_hold");
    op(1, 1, 0, 3'b000, 0, 8'hA5, 8'hA5, 1'b1, "load_a5");

    // Reset in the middle of a cycle, then held across an edge with a load pending.
    @(negedge clk);
    bus.SC_RegUNIVERSAL_mode_InBUS = 3'b101;
    #2;
    rst_n = 1'b0;
    push(8'h00, 1'b1, "async_reset");
    -> sample_ev;
    op(0, 1, 0, 3'b101, 1, 8'h77, 8'h00, 1'b1, "reset_held");
    op(1, 1, 1, 3'b110, 0, 8'h00, 8'hFF, 1'b0, "release_dec_from_0");

    op(1, 0, 0, 3'b101, 0, 8'h3C, 8'h00, 1'b1, "clear_beats_load");
    op(1, 1, 0, 3'b101, 0, 8'h3C, 8'h3C, 1'b1, "load_beats_mode");

    op(1, 1, 0, 3'b000, 0, 8'hFE, 8'hFE, 1'b1, "load_fe");
    op(1, 1, 1, 3'b101, 1, 8'h00, 8'hFF, 1'b1, "inc_to_ff");
    op(1, 1, 1, 3'b101, 0, 8'h00, 8'h00, 1'b0, "inc_wrap");

    op(1, 1, 0, 3'b000, 0, 8'h01, 8'h01, 1'b1, "load_01");
    op(1, 1, 1, 3'b110, 0, 8'h00, 8'h00, 1'b1, "dec_to_0");
    op(1, 1, 1, 3'b110, 0, 8'h00, 8'hFF, 1'b0, "dec_borrow");
    op(1, 1, 1, 3'b000, 1, 8'h12, 8'hFF, 1'b0, "hold_000");
    op(1, 1, 1, 3'b111, 1, 8'h34, 8'hFF, 1'b0, "hold_111");

    op(1, 1, 0, 3'b000, 0, 8'h81, 8'h81, 1'b1, "load_81");
    op(1, 1, 1, 3'b001, 0, 8'h00, 8'h02, 1'b0, "shl_ser0");
    op(1, 1, 1, 3'b010, 1, 8'h00, 8'h81, 1'b1, "shr_ser1");
    op(1, 1, 1, 3'b100, 0, 8'h00, 8'hC0, 1'b0, "rotr");
    op(1, 1, 1, 3'b011, 0, 8'h00, 8'h81, 1'b0, "rotl");
    op(1, 1, 1, 3'b011, 0, 8'h00, 8'h03, 1'b0, "rotl_again");
    op(1, 1, 1, 3'b100, 0, 8'h00, 8'h81, 1'b0, "rotr_lsb1");
    op(1, 0, 1, 3'b001, 1, 8'h00, 8'h00, 1'b1, "clear");

    // Random regression against a reference model, including occasional resets.
    m_r = 8'h00;
    m_c = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rn  = ($urandom_range(0, 39) != 0);
      cl  = ($urandom_range(0, 15) != 0);
      ld  = ($urandom_range(0, 7) != 0);
      md  = 3'($urandom_range(0, 7));
      sr  = 1'($urandom_range(0, 1));
      din = 8'($urandom_range(0, 255));
      nx_r = m_r;
      nx_c = m_c;
      if (!rn) begin
        nx_r = 8'h00; nx_c = 1'b0;
      end else if (!cl) begin
        nx_r = 8'h00; nx_c = 1'b0;
      end else if (!ld) begin
        nx_r = din;   nx_c = 1'b0;
      end else begin
        case (md)
          3'd1: begin nx_c = m_r[7]; nx_r = (m_r << 1) | {7'b0, sr}; end
          3'd2: begin nx_c = m_r[0]; nx_r = (m_r >> 1) | {sr, 7'b0}; end
          3'd3: begin nx_c = m_r[7]; nx_r = (m_r << 1) | (m_r >> 7); end
          3'd4: begin nx_c = m_r[0]; nx_r = (m_r >> 1) | (m_r << 7); end
          3'd5: begin nx_c = (m_r == 8'hFF); nx_r = m_r + 8'd1; end
          3'd6: begin nx_c = (m_r == 8'h00); nx_r = m_r - 8'd1; end
          default: ;
        endcase
      end
      m_r = nx_r;
      m_c = nx_c;
      op(rn, cl, ld, md, sr, din, m_r, ~m_c, "random");
    end

    @(negedge clk);
    rst_n = 1'b1;
    bus.SC_RegUNIVERSAL_clear_InLow = 1'b1;
    bus.SC_RegUNIVERSAL_load_InLow  = 1'b1;
    bus.SC_RegUNIVERSAL_mode_InBUS  = 3'b000;
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
